batch_out_fifo: RTL and testbench

// - Output buffer directly downstream of the batch fixed-point filter: takes its OUT_WIDTH-bit offset-binary

---
 rtl/batch_out_fifo.sv | 144 ++++++++++++++
 tb/tb_batch_out_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/batch_out_fifo.sv
// batch_out_fifo
//   Output buffer behind the batch fixed-point filter. It discards the first
//   SKIP valid words after reset/flush so the filter can settle. It can also
//   convert offset-binary to two's complement. It absorbs consumer stalls in a
//   DEPTH-entry first-word-fall-through FIFO, and it flags and counts words
//   lost to overflow.
//
// Ports
//   clk        in   sample clock (same as filter output)
//   rst        in   asynchronous reset, active low
//   flush      in   synchronous clear: empty FIFO, clear flags, restart skip
//   in_data    in   filter result word (offset binary)
//   in_valid   in   in_data valid this cycle (no upstream backpressure)
//   out_data   out  head-of-FIFO word, 0 while empty
//   out_valid  out  FIFO non-empty
//   out_ready  in   consumer accepts out_data this cycle
//   level      out  current occupancy, 0..DEPTH
//   overflow   out  sticky: at least one word dropped
//   drop_cnt   out  number of dropped words, saturating
module batch_out_fifo #(
    parameter int OUT_WIDTH  = 14,
    parameter int DEPTH      = 16,
    parameter int SKIP       = 4,
    parameter int SIGNED_OUT = 1,
    parameter int CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [OUT_WIDTH-1:0]   in_data,
    input  logic                   in_valid,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam int PW  = $clog2(DEPTH);
    localparam int LW  = PW + 1;
    localparam int SKW = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam logic [SKW-1:0] SKIP_LAST = SKW'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [OUT_WIDTH-1:0] MSB_MASK = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic {S_SKIP = 1'b0, S_RUN = 1'b1} state_e;
    // With SKIP == 0 there is nothing to discard, so start straight in RUN.
    localparam state_e START_ST = (SKIP == 0) ? S_RUN : S_SKIP;

    state_e               state_q, state_d;
    logic [SKW-1:0]       skip_cnt_q, skip_cnt_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_W-1:0]     drop_q, drop_d;
    logic [OUT_WIDTH-1:0] mem_q [DEPTH];

    logic                 full, empty, push, pop, drop;
    logic [OUT_WIDTH-1:0] conv_data;

    // Inverting the MSB maps offset binary onto two's complement.
    assign conv_data = (SIGNED_OUT != 0) ? (in_data ^ MSB_MASK) : in_data;

    // Full and empty come from the occupancy count, which avoids the usual
    // pointer-equality ambiguity.
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

    // flush takes priority, so it blocks every FIFO action in its cycle.
    // Because a pop frees a slot, a push is allowed on a full FIFO in the same cycle.
    assign pop  = !flush && !empty && out_ready;
    assign push = !flush && (state_q == S_RUN) && in_valid && (!full || pop);
    assign drop = !flush && (state_q == S_RUN) && in_valid && full && !pop;

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q;
        drop_d     = drop_q;
        if (flush) begin
            state_d    = START_ST;
            skip_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            ovf_d      = 1'b0;
            drop_d     = '0;
        end else begin
            if (state_q == S_SKIP && in_valid) begin
                if (skip_cnt_q == SKIP_LAST) begin
                    state_d    = S_RUN;
                    skip_cnt_d = '0;
                end else begin
                    skip_cnt_d = skip_cnt_q + 1'b1;
                end
            end
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      level_d = level_q + 1'b1;
            else if (pop && !push) level_d = level_q - 1'b1;
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != '1) drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= START_ST;
            skip_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
        end
    end

    // The storage array is not reset. The output is forced to zero while the
    // FIFO is empty, so stale contents never become visible.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= conv_data;
    end

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign level     = level_q;
    assign overflow  = ovf_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_batch_out_fifo.sv
module tb_batch_out_fifo;
    localparam int W  = 14;
    localparam int D  = 16;
    localparam int SK = 4;
    localparam int SO = 1;
    localparam int CW = 8;

    logic          clk = 1'b0, rst = 1'b0, flush = 1'b0;
    logic          in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic [W-1:0]  out_data;
    logic          out_valid, overflow;
    logic [$clog2(D):0] level;
    logic [CW-1:0] drop_cnt;

    batch_out_fifo #(.OUT_WIDTH(W), .DEPTH(D), .SKIP(SK), .SIGNED_OUT(SO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // Behavioural model: a queue of converted words plus skip/drop bookkeeping.
    logic [W-1:0] mq[$];
    int skip_left, m_drops;
    bit m_ovf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] conv(input logic [W-1:0] d);
        if (SO != 0) return W'((int'(d) + (1 << (W-1))) % (1 << W));
        return d;
    endfunction

    task automatic model_reset();
        mq.delete();
        skip_left = SK;
        m_ovf = 1'b0;
        m_drops = 0;
    endtask

    task automatic model_clock();
        bit pop, acc;
        if (!rst || flush) begin
            model_reset();
            return;
        end
        pop = (mq.size() > 0) && out_ready;
        acc = 1'b0;
        if (in_valid) begin
            if (skip_left > 0) skip_left--;
            else if (mq.size() < D || pop) acc = 1'b1;
            else begin
                m_ovf = 1'b1;
                if (m_drops < (1 << CW) - 1) m_drops++;
            end
        end
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(conv(in_data));
    endtask

    task automatic compare();
        logic [W-1:0] head;
        head = (mq.size() > 0) ? mq[0] : '0;
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("out_data",  32'(out_data),  32'(head));
        chk("level",     32'(level),     32'(mq.size()));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("drop_cnt",  32'(drop_cnt),  32'(m_drops));
    endtask

    // Advance one clock: update the model from the inputs seen at the edge,
    // then compare shortly after. Callers change inputs after step returns.
    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        compare();
    endtask

    task automatic idle(input bit v, input bit r);
        in_valid = v;
        out_ready = r;
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data), 0);
        chk("rst_level",     32'(level), 0);
        chk("rst_overflow",  32'(overflow), 0);
        chk("rst_drop_cnt",  32'(drop_cnt), 0);
        step();
        rst = 1'b1;

        // Skip settling words, stream 0..9 with the consumer always ready.
        idle(1, 1);
        for (int i = 0; i < 10; i++) begin
            in_data = W'(i);
            step();
            if (i == 4) chk("first_word_after_skip", 32'(out_data), 32'h2004);
            if (i == 5) chk("second_word", 32'(out_data), 32'h2005);
        end
        idle(0, 1);
        step();
        chk("drained", 32'(out_valid), 0);

        // Conversion pins.
        idle(1, 0);
        in_data = 14'h2000; step();
        in_data = 14'h3FFF; step();
        in_data = 14'h0000; step();
        idle(0, 0);
        step();
        chk("conv_2000", 32'(out_data), 32'h0000);
        out_ready = 1'b1; step();
        chk("conv_3FFF", 32'(out_data), 32'h1FFF);
        step();
        chk("conv_0000", 32'(out_data), 32'h2000);
        step();

        // Overflow: flush, skip 4, then 20 words into a stalled consumer.
        flush = 1'b1; step(); flush = 1'b0;
        idle(1, 0);
        for (int i = 0; i < 24; i++) begin
            in_data = W'(16'h100 + i);
            step();
        end
        chk("ovf_level", 32'(level), 16);
        chk("ovf_flag",  32'(overflow), 1);
        chk("ovf_drops", 32'(drop_cnt), 4);
        // A push on a full FIFO, with a pop in the same cycle, is not a drop.
        idle(1, 1); in_data = 14'h0ABC; step();
        chk("full_pushpop_level", 32'(level), 16);
        chk("full_pushpop_drops", 32'(drop_cnt), 4);
        idle(0, 1);
        for (int i = 0; i < 17; i++) step();

        // Saturation of the drop counter.
        idle(1, 0);
        for (int i = 0; i < 16 + 260; i++) begin
            in_data = W'($urandom);
            step();
        end
        chk("sat_drops", 32'(drop_cnt), 32'hFF);
        chk("sat_ovf",   32'(overflow), 1);

        // Flush with level 7, then confirm the skip restarts.
        flush = 1'b1; step(); flush = 1'b0;
        idle(1, 0);
        for (int i = 0; i < 11; i++) begin in_data = W'(i); step(); end
        chk("pre_flush_level", 32'(level), 7);
        flush = 1'b1; in_data = 14'h1234; step(); flush = 1'b0;
        chk("flush_level", 32'(level), 0);
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_ovf",   32'(overflow), 0);
        chk("flush_drops", 32'(drop_cnt), 0);
        idle(1, 1);
        for (int i = 0; i < 4; i++) begin in_data = W'(i + 50); step(); end
        chk("reskip_level", 32'(level), 0);
        in_data = 14'h0077; step();
        chk("reskip_first", 32'(out_data), 32'(14'h0077 ^ 14'h2000));

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 149) == 0);
            in_data   = W'($urandom);
            step();
        end
        flush = 1'b0;

        // Async reset mid-burst: outputs clear without a clock edge.
        idle(1, 0);
        for (int i = 0; i < 12; i++) begin in_data = W'($urandom); step(); end
        #3 rst = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_data",  32'(out_data), 0);
        chk("arst_level", 32'(level), 0);
        chk("arst_ovf",   32'(overflow), 0);
        chk("arst_drops", 32'(drop_cnt), 0);
        model_reset();
        step();
        rst = 1'b1;
        idle(1, 1);
        for (int i = 0; i < 8; i++) begin in_data = W'(i); step(); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
